// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control/data inputs and register/serializer outputs.
// master drives the controls, slave is the register itself.
interface universal_shift_reg_if #(
  parameter int unsigned Width = 8
);
  logic             enable;
  logic [2:0]       mode;
  logic [Width-1:0] d;
  logic             sin_left;
  logic             sin_right;
  logic [Width-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output enable, mode, d, sin_left, sin_right,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  enable, mode, d, sin_left, sin_right,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal register: hold/load/shift/rotate/arithmetic-shift plus an MSB-first
// serializer with busy/done handshake.
module universal_shift_reg #(
  parameter int unsigned     Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input logic                clk_i,
  input logic                rst_ni,
  universal_shift_reg_if.slave sr_io
);

  localparam int unsigned     CntW    = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] q_q, q_d;
  logic             done_q;

  always_comb begin
    q_d = q_q;
    if (state_q == StSend) begin
      q_d = {q_q[Width-2:0], 1'b0};
    end else begin
      unique case (sr_io.mode)
        3'b000: q_d = q_q;
        3'b001: q_d = sr_io.d;
        3'b010: q_d = {q_q[Width-2:0], sr_io.sin_right};
        3'b011: q_d = {sr_io.sin_left, q_q[Width-1:1]};
        3'b100: q_d = {q_q[Width-2:0], q_q[Width-1]};
        3'b101: q_d = {q_q[0], q_q[Width-1:1]};
        3'b110: q_d = {q_q[Width-1], q_q[Width-1:1]};
        3'b111: q_d = q_q;
      endcase
    end
  end

  // done clears on every edge, even while disabled, so it never lasts more than a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= ResetValue;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sr_io.enable) begin
        q_q <= q_d;
        case (state_q)
          StIdle: begin
            if (sr_io.mode == 3'b111) begin
              state_q <= StSend;
              cnt_q   <= CntLast;
            end
          end
          StSend: begin
            if (cnt_q == '0) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sr_io.q       = q_q;
  assign sr_io.busy    = (state_q == StSend);
  assign sr_io.ser_out = (state_q == StSend) & q_q[Width-1];
  assign sr_io.done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed cases plus random stimulus
// compared every cycle against a word-level behavioural model.
module tb_universal_shift_reg;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  universal_shift_reg_if #(.Width(W)) bus ();

  universal_shift_reg #(
    .Width     (W),
    .ResetValue(RV)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sr_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a serialization is tracked as the captured word plus how many bits have gone out.
  logic [7:0] m_q;
  logic [7:0] m_orig;
  bit         m_send;
  bit         m_done;
  int         m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    = RV;
      m_orig = '0;
      m_send = 1'b0;
      m_done = 1'b0;
      m_idx  = 0;
    end else begin
      m_done = 1'b0;
      if (bus.enable) begin
        if (m_send) begin
          m_idx++;
          if (m_idx == W) begin
            m_send = 1'b0;
            m_done = 1'b1;
            m_q    = '0;
          end else begin
            m_q = 8'((int'(m_orig) << m_idx) % 256);
          end
        end else begin
          case (bus.mode)
            3'd1: m_q = bus.d;
            3'd2: m_q = 8'(((int'(m_q) * 2) % 256) + int'(bus.sin_right));
            3'd3: m_q = 8'((int'(m_q) / 2) + 128 * int'(bus.sin_left));
            3'd4: m_q = 8'(((int'(m_q) * 2) % 256) + int'(m_q) / 128);
            3'd5: m_q = 8'((int'(m_q) / 2) + 128 * (int'(m_q) % 2));
            3'd6: m_q = 8'((int'(m_q) / 2) + (int'(m_q) / 128) * 128);
            3'd7: begin
              m_send = 1'b1;
              m_orig = m_q;
              m_idx  = 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    check("q", 32'(bus.q), 32'(m_q));
    check("busy", 32'(bus.busy), 32'(m_send));
    check("ser_out", 32'(bus.ser_out), m_send ? 32'(m_orig[7-m_idx]) : 32'd0);
    check("done", 32'(bus.done), 32'(m_done));
  end

  task automatic op(input logic [2:0] mode, input logic [7:0] d, input logic sl, input logic sr);
    bus.enable    = 1'b1;
    bus.mode      = mode;
    bus.d         = d;
    bus.sin_left  = sl;
    bus.sin_right = sr;
    @(posedge clk);
    #1;
    bus.mode = 3'd0;
  endtask

  task automatic run_ser(input bit stall, input bit abort);
    int   nb;
    int   nd;
    int   dc;
    int   len;
    bit   seq[$];
    int   exp_nom[8]    = '{1, 0, 1, 1, 0, 1, 0, 0};
    int   exp_stall[10] = '{1, 0, 1, 1, 1, 1, 0, 1, 0, 0};
    op(3'd1, 8'hB4, 1'b0, 1'b0);
    check("ser_preload", 32'(bus.q), 32'hB4);
    bus.mode = 3'd7;
    @(posedge clk);
    #1;
    bus.mode = 3'd1;
    bus.d    = 8'hFF;
    nb = 0;
    nd = 0;
    dc = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        seq.push_back(bus.ser_out);
        nb++;
      end
      if (bus.done) begin
        nd++;
        dc = c;
        check("ser_q_at_done", 32'(bus.q), 32'h0);
        bus.mode = 3'd0;
      end
      if (abort && c == 4) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_q", 32'(bus.q), 32'(RV));
        check("abort_ser_out", 32'(bus.ser_out), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        bus.mode = 3'd0;
        #1 rst_n = 1'b1;
      end
      bus.enable = !(stall && (c == 3 || c == 4));
    end
    bus.enable = 1'b1;
    bus.mode   = 3'd0;
    if (abort) begin
      check("abort_busy_cycles", 32'(nb), 32'd5);
      check("abort_no_done", 32'(nd), 32'd0);
    end else begin
      len = stall ? 10 : 8;
      check("ser_busy_cycles", 32'(nb), 32'(len));
      check("ser_done_count", 32'(nd), 32'd1);
      check("ser_done_cycle", 32'(dc), 32'(len));
      check("ser_len", 32'(seq.size()), 32'(len));
      for (int i = 0; i < len && i < seq.size(); i++) begin
        check("ser_bit", 32'(seq[i]), stall ? 32'(exp_stall[i]) : 32'(exp_nom[i]));
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.mode      = 3'd0;
    bus.d         = '0;
    bus.sin_left  = 1'b0;
    bus.sin_right = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check("reset_q", 32'(bus.q), 32'(RV));

    // Asynchronous reset mid-cycle, checked before any further edge.
    op(3'd1, 8'h3C, 1'b0, 1'b0);
    check("load_3c", 32'(bus.q), 32'h3C);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(bus.q), 32'(RV));
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_ser", 32'(bus.ser_out), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    op(3'd1, 8'h96, 1'b0, 1'b0);
    check("load_96", 32'(bus.q), 32'h96);
    op(3'd2, 8'h00, 1'b0, 1'b1);
    check("shl", 32'(bus.q), 32'h2D);
    op(3'd1, 8'h96, 1'b0, 1'b0);
    op(3'd6, 8'h00, 1'b0, 1'b0);
    check("asr", 32'(bus.q), 32'hCB);
    op(3'd1, 8'h96, 1'b0, 1'b0);
    op(3'd3, 8'h00, 1'b0, 1'b0);
    check("shr", 32'(bus.q), 32'h4B);
    op(3'd0, 8'hFF, 1'b1, 1'b1);
    check("hold", 32'(bus.q), 32'h4B);
    op(3'd1, 8'h81, 1'b0, 1'b0);
    op(3'd4, 8'h00, 1'b0, 1'b0);
    check("rol", 32'(bus.q), 32'h03);
    op(3'd1, 8'h81, 1'b0, 1'b0);
    op(3'd5, 8'h00, 1'b0, 1'b0);
    check("ror", 32'(bus.q), 32'hC0);
    op(3'd1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) op(3'd4, 8'h00, 1'b0, 1'b0);
    check("rol8", 32'(bus.q), 32'h81);
    bus.enable = 1'b0;
    bus.mode   = 3'd1;
    bus.d      = 8'h55;
    @(posedge clk);
    #1;
    check("enable_low_hold", 32'(bus.q), 32'h81);

    run_ser(1'b0, 1'b0);
    run_ser(1'b1, 1'b0);
    run_ser(1'b0, 1'b1);
    run_ser(1'b0, 1'b0);

    // Random stimulus, checked by the per-cycle compare process.
    for (int i = 0; i < 600; i++) begin
      bus.enable    = ($urandom_range(0, 9) < 8);
      bus.mode      = 3'($urandom_range(0, 7));
      bus.d         = 8'($urandom);
      bus.sin_left  = 1'($urandom);
      bus.sin_right = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.enable = 1'b1;
    bus.mode   = 3'd0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
